// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 direction-key front end: btnstate codes,
// prefix bytes, the scan-set-2 direction keys, and the key lookup helper.
package ps2_pkg;

    localparam logic [3:0] BTN_UP    = 4'b0000;
    localparam logic [3:0] BTN_DOWN  = 4'b0001;
    localparam logic [3:0] BTN_LEFT  = 4'b0010;
    localparam logic [3:0] BTN_RIGHT = 4'b0011;
    localparam logic [3:0] BTN_IDLE  = 4'b1111;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    localparam logic [7:0] SC_EXT_UP    = 8'h75;
    localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
    localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
    localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_D         = 8'h23;

    // Direction index doubles as the key_held bit position.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef struct packed {
        logic hit;
        dir_e dir;
    } key_lookup_t;

    function automatic key_lookup_t lookup_key(input logic ext, input logic [7:0] code);
        key_lookup_t r;
        r.hit = 1'b1;
        r.dir = DIR_UP;
        if (ext) begin
            case (code)
                SC_EXT_UP:    r.dir = DIR_UP;
                SC_EXT_DOWN:  r.dir = DIR_DOWN;
                SC_EXT_LEFT:  r.dir = DIR_LEFT;
                SC_EXT_RIGHT: r.dir = DIR_RIGHT;
                default:      r.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:    r.dir = DIR_UP;
                SC_S:    r.dir = DIR_DOWN;
                SC_A:    r.dir = DIR_LEFT;
                SC_D:    r.dir = DIR_RIGHT;
                default: r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [3:0] dir_code(input dir_e d);
        logic [3:0] c;
        case (d)
            DIR_UP:    c = BTN_UP;
            DIR_DOWN:  c = BTN_DOWN;
            DIR_LEFT:  c = BTN_LEFT;
            default:   c = BTN_RIGHT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: line synchronizers, ps2_clk glitch filter, 11-bit frame
// capture with odd-parity/stop check and a mid-frame inactivity timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    output logic       frame_err_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          flt_level_q, flt_level_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_edge;
    logic          ps2c;
    logic          ps2d;

    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic [7:0]    byte_q, byte_d;
    logic          err_q, err_d;

    assign ps2c = clk_sync_q[1];
    assign ps2d = data_sync_q[1];

    // A level change is accepted only after FILTER_LEN consecutive samples of the new level.
    always_comb begin
        flt_level_d = flt_level_q;
        flt_cnt_d   = '0;
        fall_edge   = 1'b0;
        if (ps2c != flt_level_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                flt_level_d = ps2c;
                fall_edge   = ~ps2c;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        valid_d = 1'b0;
        byte_d  = byte_q;
        err_d   = 1'b0;
        if (fall_edge) begin
            tmo_d = TW'(TIMEOUT_CYC - 1);
            if (bit_q == 4'd0) begin
                if (!ps2d) begin
                    bit_d = 4'd1;
                end
            end else if (bit_q <= 4'd8) begin
                shift_d = {ps2d, shift_q[7:1]};
                bit_d   = bit_q + 4'd1;
            end else if (bit_q == 4'd9) begin
                par_d = ps2d;
                bit_d = 4'd10;
            end else begin
                bit_d = 4'd0;
                if ((^{shift_q, par_q}) && ps2d) begin
                    valid_d = 1'b1;
                    byte_d  = shift_q;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (bit_q != 4'd0) begin
            if (tmo_q == '0) begin
                bit_d = 4'd0;
                err_d = 1'b1;
            end else begin
                tmo_d = tmo_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            flt_level_q <= 1'b1;
            flt_cnt_q   <= '0;
            bit_q       <= 4'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            byte_q      <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            flt_level_q <= flt_level_d;
            flt_cnt_q   <= flt_cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            byte_q      <= byte_d;
            err_q       <= err_d;
        end
    end

    assign rx_valid_o  = valid_q;
    assign rx_byte_o   = byte_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/ps2_btn_decoder.sv
// PS/2 direction-key decoder: prefix FSM over received bytes, held-key mask,
// last-pressed direction and the registered btnstate level.
//   state      | meaning
//   ST_IDLE    | no prefix pending; next byte is a normal make code
//   ST_EXT     | E0 seen; next byte is an extended make code
//   ST_BRK     | F0 seen; next byte is a normal break code
//   ST_EXT_BRK | E0 F0 seen; next byte is an extended break code
module ps2_btn_decoder
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN  = 8,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [3:0] IDLE_CODE   = BTN_IDLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] btnstate,
    output logic [3:0] key_held,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  held_q, held_d;
    dir_e        last_dir_q, last_dir_d;
    logic [3:0]  btn_q, btn_d;
    key_lookup_t key;
    logic        is_ext;
    logic        is_brk;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk_i       (clk),
        .rst_i       (rst),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .rx_valid_o  (rx_valid),
        .rx_byte_o   (rx_byte),
        .frame_err_o (frame_err)
    );

    assign is_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign is_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    assign key    = lookup_key(is_ext, rx_byte);

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        last_dir_d = last_dir_q;
        if (rx_valid) begin
            if (rx_byte == SC_E0) begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_EXT;
                end
            end else if (rx_byte == SC_F0) begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end
            end else begin
                state_d = ST_IDLE;
                if (key.hit) begin
                    if (is_brk) begin
                        held_d[key.dir] = 1'b0;
                    end else begin
                        held_d[key.dir] = 1'b1;
                        last_dir_d      = key.dir;
                    end
                end
            end
        end
    end

    // Most recent press wins while held; otherwise fixed priority up > down > left > right.
    always_comb begin
        btn_d = IDLE_CODE;
        if (held_q[last_dir_q]) begin
            btn_d = dir_code(last_dir_q);
        end else if (held_q[DIR_UP]) begin
            btn_d = BTN_UP;
        end else if (held_q[DIR_DOWN]) begin
            btn_d = BTN_DOWN;
        end else if (held_q[DIR_LEFT]) begin
            btn_d = BTN_LEFT;
        end else if (held_q[DIR_RIGHT]) begin
            btn_d = BTN_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            held_q     <= 4'b0000;
            last_dir_q <= DIR_UP;
            btn_q      <= IDLE_CODE;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            last_dir_q <= last_dir_d;
            btn_q      <= btn_d;
        end
    end

    assign btnstate = btn_q;
    assign key_held = held_q;

endmodule

// File: tb/tb_ps2_btn_decoder.sv
// Directed and randomized PS/2 frames against a key-state reference model.
module tb_ps2_btn_decoder;

    localparam int H   = 16;
    localparam int TMO = 2000;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] btnstate;
    logic [3:0] key_held;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    ps2_btn_decoder #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TMO),
        .IDLE_CODE   (4'b1111)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .btnstate  (btnstate),
        .key_held  (key_held),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Output monitor, sampled on the falling clock edge.
    int         cyc = 0;
    int         rxv_hi = 0;
    int         ferr_hi = 0;
    int         rxv_cyc = 0;
    int         held_cyc = 0;
    int         btn_cyc = 0;
    logic [7:0] mon_byte = 8'h00;
    logic [3:0] prev_held = 4'h0;
    logic [3:0] prev_btn = 4'hF;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid === 1'b1) begin
            rxv_hi++;
            rxv_cyc  = cyc;
            mon_byte = rx_byte;
        end
        if (frame_err === 1'b1) ferr_hi++;
        if (key_held !== prev_held) held_cyc = cyc;
        if (btnstate !== prev_btn) btn_cyc = cyc;
        prev_held = key_held;
        prev_btn  = btnstate;
    end

    // Reference model: held set per direction, last pressed direction, prefix flags.
    bit [3:0] m_held;
    int       m_last;
    bit       m_ext;
    bit       m_brk;
    int       exp_rxv;
    int       exp_ferr;

    function automatic int map_code(input bit ext, input logic [7:0] b);
        logic [7:0] ext_tab [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
        logic [7:0] std_tab [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
        for (int i = 0; i < 4; i++) begin
            if (ext && ext_tab[i] == b) return i;
            if (!ext && std_tab[i] == b) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 4'b0000;
        m_last = 0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int d;
        if (b == 8'hE0) begin
            if (!m_ext && !m_brk) m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            d = map_code(m_ext, b);
            if (d >= 0) begin
                if (m_brk) m_held[d] = 1'b0;
                else begin
                    m_held[d] = 1'b1;
                    m_last    = d;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    function automatic logic [3:0] exp_btn();
        if (m_held[m_last]) return 4'(m_last);
        for (int i = 0; i < 4; i++) if (m_held[i]) return 4'(i);
        return 4'b1111;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic good_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
        model_byte(b);
        exp_rxv++;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".held"}, 32'(key_held), 32'(m_held));
        check({tag, ".btn"}, 32'(btnstate), 32'(exp_btn()));
    endtask

    logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72,
                              8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h12, 8'h00};

    initial begin
        logic [7:0] rb;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        exp_rxv  = 0;
        exp_ferr = 0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.btn", 32'(btnstate), 32'hF);
        check("rst.held", 32'(key_held), 32'h0);
        check("rst.rxv", 32'(rx_valid), 32'h0);
        check("rst.byte", 32'(rx_byte), 32'h0);
        check("rst.ferr", 32'(frame_err), 32'h0);

        // Single make code and output latency.
        good_byte(8'h1D);
        check("t1.byte", 32'(mon_byte), 32'h1D);
        check("t1.rxv", 32'(rxv_hi), 32'(exp_rxv));
        check("t1.held", 32'(key_held), 32'h1);
        check("t1.btn", 32'(btnstate), 32'h0);
        check("t1.held_lat", 32'(held_cyc - rxv_cyc), 32'd1);
        check("t1.btn_lat", 32'(btn_cyc - rxv_cyc), 32'd2);
        good_byte(8'hF0);
        good_byte(8'h1D);
        check_state("t1.rel");

        // Extended arrows: last pressed wins, fallback on release.
        good_byte(8'hE0); good_byte(8'h74);
        check("t2.right", 32'(btnstate), 32'h3);
        good_byte(8'hE0); good_byte(8'h6B);
        check("t2.left", 32'(btnstate), 32'h2);
        good_byte(8'hE0); good_byte(8'hF0); good_byte(8'h6B);
        check("t2.back", 32'(btnstate), 32'h3);
        check("t2.held", 32'(key_held), 32'h8);

        // Parity and stop-bit errors.
        send_frame(8'h75, 1'b1, 1'b0, 11);
        exp_ferr++;
        check("t3.ferr", 32'(ferr_hi), 32'(exp_ferr));
        check("t3.rxv", 32'(rxv_hi), 32'(exp_rxv));
        check("t3.held", 32'(key_held), 32'h8);
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        exp_ferr++;
        check("t3.stop_ferr", 32'(ferr_hi), 32'(exp_ferr));
        check_state("t3.stop");
        good_byte(8'hE0); good_byte(8'hF0); good_byte(8'h74);
        check("t3.idle", 32'(btnstate), 32'hF);

        // Mid-frame timeout, then recovery.
        send_frame(8'h1B, 1'b0, 1'b0, 5);
        repeat (TMO - 100) @(negedge clk);
        check("t4.early", 32'(ferr_hi), 32'(exp_ferr));
        repeat (200) @(negedge clk);
        exp_ferr++;
        check("t4.ferr", 32'(ferr_hi), 32'(exp_ferr));
        check("t4.rxv", 32'(rxv_hi), 32'(exp_rxv));
        good_byte(8'h1B);
        check("t4.btn", 32'(btnstate), 32'h1);
        good_byte(8'hF0); good_byte(8'h1B);

        // Two WASD keys, release one then the other.
        good_byte(8'h1D); good_byte(8'h1B);
        good_byte(8'hF0); good_byte(8'h1B);
        check("t5.up", 32'(btnstate), 32'h0);
        good_byte(8'hF0); good_byte(8'h1D);
        check("t5.btn", 32'(btnstate), 32'hF);
        check("t5.held", 32'(key_held), 32'h0);

        // Randomized byte stream against the model.
        for (int n = 0; n < 40; n++) begin
            rb = pool[$urandom_range(0, 11)];
            if (rb == 8'h00) rb = 8'($urandom_range(0, 255));
            good_byte(rb);
            check("rnd.byte", 32'(mon_byte), 32'(rb));
            check_state("rnd");
        end
        check("rnd.rxv", 32'(rxv_hi), 32'(exp_rxv));
        check("rnd.ferr", 32'(ferr_hi), 32'(exp_ferr));

        // Reset in the middle of a frame.
        good_byte(8'hF0); good_byte(8'h1C);
        good_byte(8'h1C);
        send_frame(8'h23, 1'b0, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        check("t6.btn", 32'(btnstate), 32'hF);
        check("t6.held", 32'(key_held), 32'h0);
        check("t6.rxv", 32'(rx_valid), 32'h0);
        check("t6.byte", 32'(rx_byte), 32'h0);
        check("t6.ferr", 32'(frame_err), 32'h0);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        good_byte(8'h23);
        check("t6.after", 32'(btnstate), 32'h3);
        check("t6.noerr", 32'(ferr_hi), 32'(exp_ferr));
        check("t6.rxv", 32'(rxv_hi), 32'(exp_rxv));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
